// File: rtl/desc_pkg.sv
// Shared types and width helpers for the descriptor loader.
package desc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } desc_state_t;

    // Pixel-sum width: no overflow when all num_pix pixels are at full scale.
    function automatic int unsigned sum_w(input int unsigned pix_w, input int unsigned num_pix);
        return pix_w + int'($clog2(num_pix));
    endfunction

    // Sum-of-squares width: no overflow when all num_pix pixels are at full scale.
    function automatic int unsigned sumsq_w(input int unsigned pix_w, input int unsigned num_pix);
        return 2 * pix_w + int'($clog2(num_pix));
    endfunction

endpackage

// File: rtl/desc_stats_acc.sv
// Running pixel sum and sum of squares for the descriptor being loaded.
module desc_stats_acc
    import desc_pkg::*;
#(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned NUM_PIX = 256,
    localparam int unsigned SUM_W  = sum_w(PIX_W, NUM_PIX),
    localparam int unsigned SQ_W   = sumsq_w(PIX_W, NUM_PIX)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             acc,
    input  logic [PIX_W-1:0] pix,
    output logic [SUM_W-1:0] sum,
    output logic [SQ_W-1:0]  sumsq
);

    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SQ_W-1:0]  sumsq_q, sumsq_d;
    logic [SQ_W-1:0]  pix_sq;

    assign pix_sq = SQ_W'(pix) * SQ_W'(pix);

    // Clear at load start, accumulate each accepted beat.
    always_comb begin
        sum_d   = sum_q;
        sumsq_d = sumsq_q;
        if (clr) begin
            sum_d   = '0;
            sumsq_d = '0;
        end else if (acc) begin
            sum_d   = sum_q + SUM_W'(pix);
            sumsq_d = sumsq_q + pix_sq;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            sumsq_q <= '0;
        end else begin
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
        end
    end

    assign sum   = sum_q;
    assign sumsq = sumsq_q;

endmodule

// File: rtl/desc_loader.sv
// Multi-slot descriptor loader: assembles pixel beats into committed slots.
// Optional per-slot sum / sum-of-squares statistics under DESC_STATS_EN.
module desc_loader
    import desc_pkg::*;
#(
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned NUM_PIX  = 256,
    parameter int unsigned NUM_DESC = 4,
    localparam int unsigned SLOT_W  = $clog2(NUM_DESC),
    localparam int unsigned DESC_W  = NUM_PIX * PIX_W,
    localparam int unsigned SUM_W   = sum_w(PIX_W, NUM_PIX),
    localparam int unsigned SQ_W    = sumsq_w(PIX_W, NUM_PIX)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SLOT_W-1:0]   start_slot,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PIX_W-1:0]    in_data,
    input  logic [SLOT_W-1:0]   rd_slot,
    output logic [DESC_W-1:0]   desc_out,
    output logic [SUM_W-1:0]    sum_out,
    output logic [SQ_W-1:0]     sumsq_out,
    output logic [NUM_DESC-1:0] slot_valid,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned CNT_W = $clog2(NUM_PIX);

    desc_state_t          state_q, state_d;
    logic [SLOT_W-1:0]    slot_sel_q, slot_sel_d;
    logic [DESC_W-1:0]    work_q, work_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_DESC-1:0]  slot_valid_q, slot_valid_d;
    logic [DESC_W-1:0]    slot_mem_q [NUM_DESC];
    logic [DESC_W-1:0]    slot_mem_d [NUM_DESC];

    logic start_accept;
    logic accept;

    assign busy         = (state_q != ST_IDLE);
    assign in_ready     = (state_q == ST_LOAD);
    assign done         = (state_q == ST_DONE);
    assign err          = start && busy;
    assign start_accept = (state_q == ST_IDLE) && start;
    assign accept       = in_ready && in_valid && !abort;

    // Next-state: start, beat shifting, abort and commit.
    always_comb begin
        state_d      = state_q;
        slot_sel_d   = slot_sel_q;
        work_d       = work_q;
        cnt_d        = cnt_q;
        slot_valid_d = slot_valid_q;
        slot_mem_d   = slot_mem_q;
        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    slot_sel_d               = start_slot;
                    slot_valid_d[start_slot] = 1'b0;
                    work_d                   = '0;
                    cnt_d                    = '0;
                    state_d                  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    work_d = {work_q[DESC_W-PIX_W-1:0], in_data};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_PIX - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                slot_mem_d[slot_sel_q]   = work_q;
                slot_valid_d[slot_sel_q] = 1'b1;
                state_d                  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and slot storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            slot_sel_q   <= '0;
            work_q       <= '0;
            cnt_q        <= '0;
            slot_valid_q <= '0;
            slot_mem_q   <= '{default: '0};
        end else begin
            state_q      <= state_d;
            slot_sel_q   <= slot_sel_d;
            work_q       <= work_d;
            cnt_q        <= cnt_d;
            slot_valid_q <= slot_valid_d;
            slot_mem_q   <= slot_mem_d;
        end
    end

    assign slot_valid = slot_valid_q;
    assign desc_out   = slot_mem_q[rd_slot];

`ifdef DESC_STATS_EN
    logic [SUM_W-1:0] acc_sum;
    logic [SQ_W-1:0]  acc_sumsq;
    logic [SUM_W-1:0] sum_mem_q [NUM_DESC];
    logic [SUM_W-1:0] sum_mem_d [NUM_DESC];
    logic [SQ_W-1:0]  sq_mem_q  [NUM_DESC];
    logic [SQ_W-1:0]  sq_mem_d  [NUM_DESC];

    desc_stats_acc #(
        .PIX_W   (PIX_W),
        .NUM_PIX (NUM_PIX)
    ) u_stats (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_accept),
        .acc   (accept),
        .pix   (in_data),
        .sum   (acc_sum),
        .sumsq (acc_sumsq)
    );

    // Commit the finished statistics alongside the descriptor.
    always_comb begin
        sum_mem_d = sum_mem_q;
        sq_mem_d  = sq_mem_q;
        if (state_q == ST_DONE) begin
            sum_mem_d[slot_sel_q] = acc_sum;
            sq_mem_d[slot_sel_q]  = acc_sumsq;
        end
    end

    // Per-slot statistics storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_mem_q <= '{default: '0};
            sq_mem_q  <= '{default: '0};
        end else begin
            sum_mem_q <= sum_mem_d;
            sq_mem_q  <= sq_mem_d;
        end
    end

    assign sum_out   = sum_mem_q[rd_slot];
    assign sumsq_out = sq_mem_q[rd_slot];
`else
    assign sum_out   = '0;
    assign sumsq_out = '0;
`endif

endmodule

// File: doc/desc_loader.md
# desc_loader

Multi-slot descriptor loader for the vision NCC datapath. Accepts pixel beats from the PCI input stream under a valid/ready handshake and assembles them into one of `NUM_DESC` descriptor slots. Each slot holds a committed descriptor plus, optionally, its pixel sum and sum of squares for NCC normalisation. It sits between the PCI byte interface and the NCC correlator, which reads any committed slot combinationally.

## Interface
- `PIX_W`, 8: bits per pixel.
- `NUM_PIX`, 256: pixels per descriptor; power of two, ≥ 2.
- `NUM_DESC`, 4: number of descriptor slots; ≥ 2.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request to load a slot; sampled in IDLE only.
- `start_slot`  in  $clog2(NUM_DESC)  target slot for `start`.
- `abort`  in  1  cancel the current load.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a beat.
- `in_data`  in  PIX_W  pixel beat.
- `rd_slot`  in  $clog2(NUM_DESC)  slot selected for read.
- `desc_out`  out  NUM_PIX*PIX_W  descriptor in `rd_slot`.
- `sum_out`  out  PIX_W+$clog2(NUM_PIX)  pixel sum of `rd_slot`.
- `sumsq_out`  out  2*PIX_W+$clog2(NUM_PIX)  sum of squares of `rd_slot`.
- `slot_valid`  out  NUM_DESC  slot holds a complete descriptor.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse, load complete.
- `err`  out  1  one-cycle pulse, `start` rejected.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE, `start`=1: latch `start_slot`, clear that slot's `slot_valid` bit, clear the working register, pixel counter and stats accumulators, then go to LOAD.
- LOAD: `in_ready`=1. A beat is accepted when `in_valid && in_ready`.
  - On each accepted beat, the working register shifts left by PIX_W with `in_data` entering the LSBs. Pixel 0 ends at the MSBs.
  - The counter increments. The beat accepted at count `NUM_PIX-1` moves the FSM to DONE.
- LOAD, `abort`=1: go to IDLE. Any beat offered that cycle is not accepted. Slot data is unchanged and its `slot_valid` stays 0. `abort` in IDLE or DONE has no effect.
- DONE: `done`=1, `in_ready`=0 for one cycle. On the exiting edge, commit the working register and stats to the slot, set its `slot_valid` bit, and go to IDLE.
- `start` while `busy`: ignored, `err` pulses for that cycle.
- During a load, the target slot's previous data stays readable until commit, but its `slot_valid` reads 0.
- Read path: `desc_out`, `sum_out` and `sumsq_out` are a combinational mux on `rd_slot`.
- Arithmetic is unsigned. Accumulator widths are sized so they never overflow at full scale.

## Timing
- Reset values: state IDLE, all slot storage 0, `slot_valid`=0, and `in_ready`, `busy`, `done`, `err`, `desc_out`, `sum_out`, `sumsq_out` all 0.
- If `rst_n` is asserted mid-load, the block returns to IDLE immediately and all slots are cleared.
- Cycle sequence for a load:
  - `start` sampled at edge 0.
  - `in_ready` is high from the cycle after edge 0.
  - With no stalls, beats are accepted at edges 1..NUM_PIX.
  - `done` is high in the cycle after edge NUM_PIX.
  - `slot_valid` rises at edge NUM_PIX+1.
- Minimum start-to-start spacing is NUM_PIX+2 cycles.
- `in_valid` gaps stall the counter with no penalty.
- `err` and `done` are combinational from state and inputs, with no added latency.

## Configuration
- `DESC_STATS_EN` defined: per-slot sum and sum-of-squares accumulators and storage are compiled in, updated per accepted beat and committed in DONE.
- `DESC_STATS_EN` undefined: no accumulators or storage, and `sum_out`/`sumsq_out` are tied to 0. All other behaviour is identical.

## Structure
- Package `desc_pkg`:
  - FSM state enum `desc_state_t`.
  - Width functions `sum_w(pix_w, num_pix)` and `sumsq_w(pix_w, num_pix)`.
- Sub-module `desc_stats_acc`: clear/accumulate/commit of sum and sumsq for one in-flight descriptor. It is instantiated only under `DESC_STATS_EN`.

## Test plan
All scenarios use PIX_W=8, NUM_PIX=4, NUM_DESC=2 unless noted; stats checks run with `DESC_STATS_EN` defined.
- Start slot 1, send 0x01,0x02,0x03,0x04 with `in_valid` held high -> `done` 5 cycles after start; `slot_valid`=2'b10; `rd_slot`=1 gives `desc_out`=0x01020304, `sum_out`=10, `sumsq_out`=30.
- Same stream with `in_valid` low on alternate cycles -> identical result; `done` 9 cycles after start.
- `start` pulsed during LOAD and during DONE -> `err` pulses in each cycle; the in-flight load completes unaffected.
- Load slot 0 with 0xAA×4, then reload it and `abort` after 2 beats -> `slot_valid[0]`=0, `desc_out` still 0xAAAAAAAA, `busy`=0 next cycle.
- Assert `rst_n`=0 after 2 beats into slot 1 -> all outputs 0 at once; a fresh full load then succeeds.
- Defaults with 0xFF×256 -> `sum_out`=65280, `sumsq_out`=16646400; without `DESC_STATS_EN` both are 0.
